// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation core: FSM states and
// the conditional modulus subtraction used to bring values back below n.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    MONT,
    CALC,
    DONE
  } rsa_state_t;

  // Widest operand the helper accepts; callers zero-extend into this and
  // take back only the low bits they need.
  localparam int unsigned RSA_MAX_W = 4096;

  typedef logic [RSA_MAX_W+1:0] rsa_wide_t;

  // Returns v - n when v >= n, otherwise v unchanged.
  function automatic rsa_wide_t cond_sub_n(input rsa_wide_t v, input rsa_wide_t n);
    cond_sub_n = (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier. Each i_step consumes one
// multiplier bit (i_xbit, LSB first) and halves the running sum after
// making it even with an optional add of n.
module rsa_mont_mul #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic             i_xbit,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH+1:0] o_s
);

  logic [WIDTH+2:0] sum_xy;
  logic [WIDTH+2:0] sum_qn;

  // Partial product then reduction term; one spare bit above s keeps the sum exact.
  always_comb begin
    sum_xy = {1'b0, o_s} + (i_xbit ? {3'b000, i_y} : '0);
    sum_qn = sum_xy + (sum_xy[0] ? {3'b000, i_n} : '0);
  end

  // Accumulator: cleared between products, shifted right once per step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_s <= '0;
    end else if (i_clear) begin
      o_s <= '0;
    end else if (i_step) begin
      o_s <= sum_qn[WIDTH+2:1];
    end
  end

endmodule

// File: rtl/rsa_modexp_core.sv
// Right-to-left binary modular exponentiation o_result = a^d mod n.
// m stays in the normal domain while t carries a^(2^k) in Montgomery form,
// so mont(m, t) needs no final conversion.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter  int unsigned WIDTH = 256,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  rsa_state_t       state, state_nx;
  logic [WIDTH-1:0] d_r, n_r, t_r, m_r;
  logic [CNT_W-1:0] j_r, k_r;
  logic [IDX_W-1:0] j_idx, k_idx;
  logic [WIDTH+1:0] res_s, sq_s;
  logic [WIDTH:0]   t_dbl;
  rsa_wide_t        t_dbl_w, m_red_w, t_red_w;
  logic             j_last, k_last, d_bit, m_bit, t_bit;
  logic             mont_clear, mont_step, halted;

  // Counter decode, operand bit selection and reduced values.
  always_comb begin
    j_last     = (j_r == LAST);
    k_last     = (k_r == LAST);
    j_idx      = j_r[IDX_W-1:0];
    k_idx      = k_r[IDX_W-1:0];
    d_bit      = d_r[k_idx +: 1];
    m_bit      = m_r[j_idx +: 1];
    t_bit      = t_r[j_idx +: 1];
    t_dbl      = {t_r, 1'b0};
    t_dbl_w    = cond_sub_n(rsa_wide_t'(t_dbl), rsa_wide_t'(n_r));
    m_red_w    = cond_sub_n(rsa_wide_t'(res_s), rsa_wide_t'(n_r));
    t_red_w    = cond_sub_n(rsa_wide_t'(sq_s), rsa_wide_t'(n_r));
    mont_step  = (state == MONT);
    mont_clear = (state != MONT);
    halted     = i_abort && (state != IDLE);
    o_busy     = (state != IDLE);
  end

  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul_res (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(mont_clear),
    .i_step (mont_step),
    .i_xbit (m_bit),
    .i_y    (t_r),
    .i_n    (n_r),
    .o_s    (res_s)
  );

  rsa_mont_mul #(.WIDTH(WIDTH)) u_mul_sq (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clear(mont_clear),
    .i_step (mont_step),
    .i_xbit (t_bit),
    .i_y    (t_r),
    .i_n    (n_r),
    .o_s    (sq_s)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; abort overrides every busy state.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_start && !i_abort) state_nx = PREP;
      PREP: if (j_last) state_nx = MONT;
      MONT: if (j_last) state_nx = CALC;
      CALC: state_nx = k_last ? DONE : MONT;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (halted) state_nx = IDLE;
  end

  // Datapath registers, counters and result/valid outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d_r      <= '0;
      n_r      <= '0;
      t_r      <= '0;
      m_r      <= '0;
      j_r      <= '0;
      k_r      <= '0;
      o_result <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!halted) begin
        unique case (state)
          IDLE: begin
            if (i_start && !i_abort) begin
              d_r <= i_d;
              n_r <= i_n;
              t_r <= i_a;
              m_r <= {{(WIDTH-1){1'b0}}, 1'b1};
              k_r <= '0;
              j_r <= '0;
            end
          end
          PREP: begin
            t_r <= t_dbl_w[WIDTH-1:0];
            j_r <= j_last ? '0 : j_r + 1'b1;
          end
          MONT: begin
            j_r <= j_last ? '0 : j_r + 1'b1;
          end
          CALC: begin
            if (d_bit) m_r <= m_red_w[WIDTH-1:0];
            t_r <= t_red_w[WIDTH-1:0];
            if (!k_last) k_r <= k_r + 1'b1;
          end
          DONE: begin
            o_result <= m_r;
            o_valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Self-checking bench for rsa_modexp_core: directed handshake scenarios on
// an 8-bit instance, random operands on 8- and 32-bit instances checked
// against a square-and-multiply reference.
module tb_rsa_modexp_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s8, ab8, busy8, val8;
  logic [7:0] a8, d8, n8, res8;

  logic        s32, ab32, busy32, val32;
  logic [31:0] a32, d32, n32, res32;

  int vectors     = 0;
  int miscompares = 0;

  localparam int LAT8  = 8 * (8 + 2) + 1;
  localparam int LAT32 = 32 * (32 + 2) + 1;

  rsa_modexp_core #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8), .i_abort(ab8),
    .i_a(a8), .i_d(d8), .i_n(n8),
    .o_busy(busy8), .o_valid(val8), .o_result(res8)
  );

  rsa_modexp_core #(.WIDTH(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(s32), .i_abort(ab32),
    .i_a(a32), .i_d(d32), .i_n(n32),
    .o_busy(busy32), .o_valid(val32), .o_result(res32)
  );

  function automatic longint unsigned modpow(input longint unsigned a,
                                             input longint unsigned d,
                                             input longint unsigned n);
    longint unsigned r = 1;
    longint unsigned b = a % n;
    longint unsigned e = d;
    while (e != 0) begin
      if (e[0]) r = (r * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return r % n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one 8-bit operation and waits (bounded) for o_valid.
  task automatic run8(input logic [7:0] a, input logic [7:0] d, input logic [7:0] n,
                      output logic [7:0] res, output int lat, output bit busy_ok);
    a8 = a; d8 = d; n8 = n; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!val8 && lat < 300) begin
      if (!busy8) busy_ok = 1'b0;
      tick();
      lat++;
    end
    res = res8;
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] d, input logic [31:0] n,
                       output logic [31:0] res, output int lat);
    a32 = a; d32 = d; n32 = n; s32 = 1'b1;
    tick();
    s32 = 1'b0;
    lat = 0;
    while (!val32 && lat < 3000) begin
      tick();
      lat++;
    end
    res = res32;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s8 = 0; ab8 = 0; a8 = '0; d8 = '0; n8 = '0;
    s32 = 0; ab32 = 0; a32 = '0; d32 = '0; n32 = '0;
    tick();
    tick();
    vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
    vectors++; if (val8 !== 1'b0) begin miscompares++; $display("FAIL reset_valid8: got %b expected 0", val8); end
    vectors++; if (res8 !== 8'd0) begin miscompares++; $display("FAIL reset_result8: got %0d expected 0", res8); end
    vectors++; if (busy32 !== 1'b0) begin miscompares++; $display("FAIL reset_busy32: got %b expected 0", busy32); end
    vectors++; if (val32 !== 1'b0) begin miscompares++; $display("FAIL reset_valid32: got %b expected 0", val32); end
    vectors++; if (res32 !== 32'd0) begin miscompares++; $display("FAIL reset_result32: got %0d expected 0", res32); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] res;
    int lat;
    bit bok;
    run8(8'd5, 8'd3, 8'd13, res, lat, bok);
    vectors++; if (res !== 8'd8) begin miscompares++; $display("FAIL basic_result: got %0d expected 8", res); end
    vectors++; if (lat !== LAT8) begin miscompares++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT8); end
    vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL basic_busy: busy dropped before valid, got %b expected 1", bok); end
    tick();
    vectors++; if (val8 !== 1'b0) begin miscompares++; $display("FAIL basic_valid_pulse: got %b expected 0", val8); end
    vectors++; if (res8 !== 8'd8) begin miscompares++; $display("FAIL basic_result_hold: got %0d expected 8", res8); end
  endtask

  task automatic test_edge_values();
    logic [7:0] res;
    int lat;
    bit bok;
    run8(8'd7, 8'd0, 8'd13, res, lat, bok);
    vectors++; if (res !== 8'd1) begin miscompares++; $display("FAIL d_zero_result: got %0d expected 1", res); end
    vectors++; if (lat !== LAT8) begin miscompares++; $display("FAIL d_zero_latency: got %0d expected %0d", lat, LAT8); end
    tick();
    run8(8'd0, 8'd5, 8'd13, res, lat, bok);
    vectors++; if (res !== 8'd0) begin miscompares++; $display("FAIL a_zero_result: got %0d expected 0", res); end
    vectors++; if (lat !== LAT8) begin miscompares++; $display("FAIL a_zero_latency: got %0d expected %0d", lat, LAT8); end
    tick();
  endtask

  task automatic test_start_ignored();
    int nval = 0;
    int vlat = -1;
    logic [7:0] vres = '0;
    a8 = 8'd5; d8 = 8'd3; n8 = 8'd13; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 20) begin a8 = 8'd9; d8 = 8'd200; n8 = 8'd251; s8 = 1'b1; end
      if (c == 22) s8 = 1'b0;
      tick();
      if (val8) begin
        nval++;
        if (nval == 1) begin vlat = c; vres = res8; end
      end
    end
    vectors++; if (nval !== 1) begin miscompares++; $display("FAIL busy_start_valid_count: got %0d expected 1", nval); end
    vectors++; if (vres !== 8'd8) begin miscompares++; $display("FAIL busy_start_result: got %0d expected 8", vres); end
    vectors++; if (vlat !== LAT8) begin miscompares++; $display("FAIL busy_start_latency: got %0d expected %0d", vlat, LAT8); end
  endtask

  task automatic test_abort();
    int nval = 0;
    logic [7:0] res;
    int lat;
    bit bok;
    a8 = 8'd3; d8 = 8'd7; n8 = 8'd13; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    for (int c = 1; c < 40; c++) tick();
    ab8 = 1'b1;
    tick();
    ab8 = 1'b0;
    vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy8); end
    vectors++; if (val8 !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b expected 0", val8); end
    vectors++; if (res8 !== 8'd8) begin miscompares++; $display("FAIL abort_result_hold: got %0d expected 8", res8); end
    for (int c = 0; c < 100; c++) begin
      tick();
      if (val8) nval++;
    end
    vectors++; if (nval !== 0) begin miscompares++; $display("FAIL abort_no_valid: got %0d pulses expected 0", nval); end
    ab8 = 1'b1; s8 = 1'b1;
    tick();
    ab8 = 1'b0; s8 = 1'b0;
    vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL abort_start_same_cycle: busy got %b expected 0", busy8); end
    tick();
    vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL abort_start_stays_idle: busy got %b expected 0", busy8); end
    run8(8'd3, 8'd7, 8'd13, res, lat, bok);
    vectors++; if (res !== 8'd3) begin miscompares++; $display("FAIL after_abort_result: got %0d expected 3", res); end
    vectors++; if (lat !== LAT8) begin miscompares++; $display("FAIL after_abort_latency: got %0d expected %0d", lat, LAT8); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] res;
    int lat;
    bit bok;
    a8 = 8'd9; d8 = 8'd200; n8 = 8'd251; s8 = 1'b1;
    tick();
    s8 = 1'b0;
    for (int c = 1; c < 30; c++) tick();
    vectors++; if (busy8 !== 1'b1) begin miscompares++; $display("FAIL pre_reset_busy: got %b expected 1", busy8); end
    rst = 1'b1;
    #1;
    vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy: got %b expected 0", busy8); end
    vectors++; if (val8 !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b expected 0", val8); end
    vectors++; if (res8 !== 8'd0) begin miscompares++; $display("FAIL mid_reset_result: got %0d expected 0", res8); end
    tick();
    rst = 1'b0;
    tick();
    run8(8'd2, 8'd10, 8'd11, res, lat, bok);
    vectors++; if (res !== 8'd1) begin miscompares++; $display("FAIL post_reset_result: got %0d expected 1", res); end
    vectors++; if (lat !== LAT8) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT8); end
    tick();
  endtask

  task automatic test_random8();
    logic [7:0] a, d, n, res, exp;
    int lat;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      n = 8'($urandom_range(1, 127) * 2 + 1);
      a = 8'($urandom % n);
      d = 8'($urandom_range(0, 255));
      if (i == 0) begin n = 8'd255; a = 8'd254; d = 8'd255; end
      exp = 8'(modpow(longint'(a), longint'(d), longint'(n)));
      run8(a, d, n, res, lat, bok);
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL rand8_result: %0d^%0d mod %0d got %0d expected %0d", a, d, n, res, exp); end
      vectors++; if (lat !== LAT8) begin miscompares++; $display("FAIL rand8_latency: got %0d expected %0d", lat, LAT8); end
      tick();
    end
  endtask

  task automatic test_random32();
    logic [31:0] a, d, n, res, exp;
    int lat;
    for (int i = 0; i < 25; i++) begin
      n = $urandom | 32'h1;
      if (n < 32'd3) n = 32'd3;
      a = 32'(longint'($urandom) % longint'(n));
      d = $urandom;
      if (i == 0) begin n = 32'hFFFF_FFFF; a = 32'hFFFF_FFFE; d = 32'hFFFF_FFFF; end
      if (i == 1) d = 32'd0;
      exp = 32'(modpow(longint'(a), longint'(d), longint'(n)));
      run32(a, d, n, res, lat);
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL rand32_result: %0d^%0d mod %0d got %0d expected %0d", a, d, n, res, exp); end
      vectors++; if (lat !== LAT32) begin miscompares++; $display("FAIL rand32_latency: got %0d expected %0d", lat, LAT32); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_values();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_random8();
    test_random32();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
Parametrised modular-exponentiation engine computing o_result = i_a^i_d mod i_n for WIDTH-bit operands, using right-to-left binary exponentiation built on radix-2 Montgomery multiplication. It is the next-generation core behind the RSA wrapper.
- Adds operand latching, busy/valid handshake, synchronous abort and a WIDTH parameter.
- Two Montgomery multipliers run concurrently, one for the result path and one for the squaring path.

Parameters:
WIDTH, 256, operand/modulus bit width (>=4)
CNT_W, $clog2(WIDTH+1), counter width (derived, not overridden)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  request; sampled only in IDLE
i_abort  in  1  synchronous abort of a running operation
i_a  in  WIDTH  base; precondition i_a < i_n
i_d  in  WIDTH  exponent
i_n  in  WIDTH  modulus; precondition odd, >1
o_busy  out  1  high in every state except IDLE
o_valid  out  1  one-cycle pulse, o_result newly valid
o_result  out  WIDTH  last completed result, held until next completion

Behaviour:
- Reset values: state IDLE, o_busy=0, o_valid=0, o_result=0, all internal registers and counters 0.
- IDLE:
  - i_start=1 and i_abort=0 latches a, d and n into internal registers on that edge. The core uses only these copies afterwards, so later input changes have no effect.
  - t<=a, m<=1, bit index k<=0, then go to PREP.
- PREP, exactly WIDTH cycles: t <= (2t >= n) ? 2t-n : 2t. Use WIDTH+1-bit arithmetic. Result is t = a*2^WIDTH mod n.
- MONT, exactly WIDTH cycles per exponent bit; both multipliers step in parallel.
  - Each keeps a WIDTH+2-bit accumulator s, cleared on MONT entry.
  - Step j: s <= (s + x_j*y + q*n) >> 1, where q is the LSB of s + x_j*y.
  - Result multiplier: x=m, y=t. Square multiplier: x=t, y=t.
- CALC, 1 cycle:
  - If d[k]=1, m <= mont_result - (mont_result>=n ? n : 0); otherwise m is unchanged.
  - t <= mont_square - (mont_square>=n ? n : 0).
  - If k==WIDTH-1, go to DONE; otherwise k<=k+1 and go to MONT.
- DONE, 1 cycle: o_result<=m, o_valid=1 for exactly this cycle, then IDLE. o_busy=1 during DONE.
- Latency from the i_start sampling edge to the o_valid cycle is WIDTH*(WIDTH+2)+1 cycles. That is 81 for WIDTH=8 and 66049 for WIDTH=256. It is data-independent.
- i_start while busy is ignored, with no queueing.
- i_abort in any non-IDLE state returns to IDLE on the next edge. There is no o_valid, and o_result keeps its previous value. i_abort together with i_start in IDLE gives no start.
- i_rst mid-operation returns everything to reset values immediately.
- d=0 yields 1; a=0 with d!=0 yields 0.
- Precondition violations (even n, a>=n) give an undefined o_result. Latency and handshake stay as specified, and the FSM never hangs.
- No arithmetic overflow is permitted. Intermediate sums use at least WIDTH+2 bits.

Decomposition:
- Package rsa_pkg: state enum (IDLE, PREP, MONT, CALC, DONE) and a shared helper function for conditional subtract of n.
- Sub-module rsa_mont_mul (parameter WIDTH), instantiated twice.
  - Ports: i_clk, i_rst, i_clear, i_step, i_xbit, i_y, i_n, o_s.
  - One bit-serial step per i_step; i_clear zeroes the accumulator.
  - The top level owns counters and bit selection, using indexed part-select, not a mux chain.

Test Plan:
1. WIDTH=8, a=5, d=3, n=13, start -> o_valid exactly 81 cycles after the start edge, o_result=8, o_busy high throughout.
2. WIDTH=8, d=0, a=7, n=13 -> o_result=1; then a=0, d=5 -> o_result=0.
3. WIDTH=8: start with a=5, d=3, n=13, then change inputs and pulse i_start mid-run -> result still 8, single o_valid, no second run.
4. WIDTH=8: abort at cycle 40 -> IDLE next cycle, no o_valid, o_result retains the previous value (8). A new start then completes correctly; abort+start in the same IDLE cycle does not start.
5. WIDTH=8: assert i_rst at cycle 30 -> outputs 0 immediately. The next run of a=2, d=10, n=11 gives 1024 mod 11 = 1.
6. WIDTH=256, 200 random odd n with a<n -> each o_result matches the reference-model modpow, and latency is always 66049.
